wb_sdram_bridge: RTL and testbench
==================================

# wb_sdram_bridge

Parametrised Wishbone-slave front end for `sdram_controller`. It replaces the direct combinational strobe/ack coupling with two buffers. A write-posting FIFO acks writes without waiting for the controller. A one-line read prefetch buffer serves sequential reads from a filled line. It sits between the user-project Wishbone port and the controller's `user_addr`/`rw`/`in_valid`/`out_valid`/`busy` interface.

## Interface
- `ADDR_W`, 23: controller word-address width.
- `DATA_W`, 32: data width. Must be 32 for the Wishbone side.
- `WFIFO_DEPTH`, 4: write-posting FIFO entries. Power of 2, ≥2.
- `LINE_WORDS`, 4: prefetch line length in words. Power of 2, ≥1.

Ports:
- `wb_clk_i` in 1: sole clock.
- `wb_rst_i` in 1: reset. Synchronous, active-high.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1 each: Wishbone classic request.
- `wbs_sel_i` in 4: byte lanes.
- `wbs_adr_i` in 32: byte address. Word address is `wbs_adr_i[ADDR_W+1:2]`.
- `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: registered single-cycle ack.
- `wbs_dat_o` out 32: read data, valid with ack.
- `ctrl_addr_o` out ADDR_W: controller word address.
- `ctrl_rw_o` out 1: 1 = write.
- `ctrl_data_o` out DATA_W: controller write data.
- `ctrl_mask_o` out 4: byte mask. Equals the entry's sel on writes, 0 on reads.
- `ctrl_in_valid_o` out 1: one-cycle command pulse.
- `ctrl_busy_i` in 1: controller cannot accept a command.
- `ctrl_data_i` in DATA_W: controller read data.
- `ctrl_out_valid_i` in 1: read data valid.

## Operation
- Request: `req = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o`. The ack term prevents a held strobe from being accepted twice.
- Write path:
  - A write request with FIFO not full pushes {word addr, data, sel}.
  - `wbs_ack_o` is asserted the next cycle.
  - When the FIFO is full, the request waits with no ack.
- Write/line coherence: a push whose word address falls in the current line (`addr[ADDR_W-1:log2 LINE_WORDS]` == line tag) clears `line_valid` in the same cycle.
- Read ordering: a read request waits until the FIFO is empty, which gives strict write-before-read ordering.
  - Hit: FIFO empty, `line_valid`, tag match. The line word is returned with ack the next cycle.
  - Miss: a refill of the aligned line starts.
- FSM states, `IDLE`, `WR_ISSUE`, `RD_ISSUE`, `RD_WAIT`, `RD_RESP`:
  - `IDLE` → `WR_ISSUE` when the FIFO is non-empty. Draining has priority over refill.
  - `IDLE` → `RD_ISSUE` on a read miss with FIFO empty. This latches the tag and sets word index = 0.
  - `WR_ISSUE`: when `~ctrl_busy_i`, pulse `ctrl_in_valid_o` with the FIFO head, pop it, and go to `IDLE`.
  - `RD_ISSUE`: when `~ctrl_busy_i`, pulse `ctrl_in_valid_o` with `rw=0` and addr = {tag, index}, then go to `RD_WAIT`.
  - `RD_WAIT`: on `ctrl_out_valid_i`, store `ctrl_data_i` at index. If index = `LINE_WORDS-1`, set `line_valid` and go to `RD_RESP`. Otherwise increment index and go to `RD_ISSUE`.
  - `RD_RESP`: ack with the requested word, then go to `IDLE`.
- Only one controller command is outstanding at any time.
- Writes arriving during a refill are still pushed and acked. The in-line invalidate check applies to the latched refill tag, and `line_valid` is then left cleared at the end of the fill. The read is still answered from the filled data. This is safe because ordering puts that write after the read.

## Timing
- Reset values:
  - All outputs 0.
  - FIFO empty, `line_valid` = 0, state `IDLE`.
- Reset mid-operation:
  - Abandons any FIFO contents and any refill. No ack is issued.
  - The controller shares the reset.
- Write ack latency: 1 cycle when the FIFO is not full.
- Drain throughput: at most 1 entry per 2 cycles (`IDLE` → `WR_ISSUE`).
- Read hit: request in cycle N → ack and data in N+1.
- Read miss: ack 1 cycle after the `ctrl_out_valid_i` of the last line word.
- Push and pop in the same cycle are both allowed. Full/empty are computed from a registered count of width log2(`WFIFO_DEPTH`)+1.
- FIFO pointers wrap modulo `WFIFO_DEPTH`.
- The index counter is log2(`LINE_WORDS`) bits. It does not wrap within a fill.

## Structure
- Package `wb_sdram_pkg`:
  - FSM state enum.
  - FIFO entry struct {addr, data, sel} and its width.
  - Localparams for index and tag widths.
- Sub-module `sync_fifo`, parametrised on width and depth, with push, pop, full, empty and head outputs.
- Line storage, tag, FSM and ack logic live in the top.

## Test plan
- Reset, then a single write to 0x10 with data 0xDEADBEEF and sel 0xF:
  - Ack in cycle +1.
  - Exactly one `ctrl_in_valid_o` with addr 4, rw=1, mask 0xF, data 0xDEADBEEF.
- Six back-to-back writes with `ctrl_busy_i` held high:
  - First 4 acked.
  - 5th stalled until busy drops and one pop occurs.
  - All 6 reach the controller in order.
- Read of 0x40 with `ctrl_data_i` model = addr+0x100:
  - 4 controller reads at addrs 16–19.
  - Ack after the 4th `out_valid` with data 0x110.
  - Then reads of 0x44, 0x48 and 0x4C each ack in 1 cycle with data 0x111, 0x112 and 0x113, and no controller traffic.
- Write to 0x44 after the line above is valid:
  - `line_valid` cleared.
  - The next read of 0x48 causes a refill, which is issued only after the write has drained.
- Assert `wb_rst_i` during `RD_WAIT` of a refill:
  - All outputs 0 the next cycle.
  - No ack.
  - A subsequent read of the same address misses.

Source files
------------

// File: rtl/wb_sdram_pkg.sv
// Shared types for the Wishbone-to-SDRAM bridge: FSM states, the posted-write entry and line geometry helpers.
package wb_sdram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    RD_ISSUE,
    RD_WAIT,
    RD_RESP
  } state_t;

  // Address is carried at full Wishbone word width; the bridge uses the low ADDR_W bits.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } wr_entry_t;

  localparam int ENTRY_W = $bits(wr_entry_t);

  // Word-offset bits inside a line (0 for single-word lines).
  function automatic int off_bits(input int line_words);
    return (line_words > 1) ? $clog2(line_words) : 0;
  endfunction

  // Fill index counter width, kept at least one bit wide.
  function automatic int idx_bits(input int line_words);
    return (line_words > 1) ? $clog2(line_words) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with a registered occupancy count.
// Latency: pushed entry visible at head the next cycle; push and pop may share a cycle.
// Backpressure: push ignored while full, pop ignored while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_dat
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/wb_sdram_bridge.sv
// Wishbone slave front end for sdram_controller with write posting and a one-line read prefetch.
// Latency: write and read-hit ack 1 cycle after accept; a miss acks 1 cycle after the last line word.
// Backpressure: writes stall while the posting FIFO is full; reads stall until the FIFO has drained.
module wb_sdram_bridge
  import wb_sdram_pkg::*;
#(
  parameter int ADDR_W      = 23,
  parameter int DATA_W      = 32,
  parameter int WFIFO_DEPTH = 4,
  parameter int LINE_WORDS  = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic [ADDR_W-1:0] ctrl_addr_o,
  output logic              ctrl_rw_o,
  output logic [DATA_W-1:0] ctrl_data_o,
  output logic [3:0]        ctrl_mask_o,
  output logic              ctrl_in_valid_o,
  input  logic              ctrl_busy_i,
  input  logic [DATA_W-1:0] ctrl_data_i,
  input  logic              ctrl_out_valid_i
);

  localparam int               OFF_W    = off_bits(LINE_WORDS);
  localparam int               IDX_W    = idx_bits(LINE_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  state_t            state;
  logic [ADDR_W-1:0] line_tag;
  logic              line_valid;
  logic              fill_dirty;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  req_off;
  logic [DATA_W-1:0] line_mem [LINE_WORDS];

  logic [ADDR_W-1:0] word_addr;
  logic [ADDR_W-1:0] req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic              req, wr_req, rd_req, push, pop, hit, push_in_line;
  logic              fifo_full, fifo_empty;
  wr_entry_t         push_ent, head_ent;
  logic              unused_bits;

  assign word_addr    = wbs_adr_i[ADDR_W+1:2];
  assign req_tag      = word_addr >> OFF_W;
  assign req_idx      = IDX_W'(word_addr) & LAST_IDX;
  assign req          = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign wr_req       = req & wbs_we_i;
  assign rd_req       = req & ~wbs_we_i;
  assign push         = wr_req & ~fifo_full;
  assign pop          = (state == WR_ISSUE) & ~ctrl_busy_i;
  assign hit          = (state == IDLE) & rd_req & fifo_empty & line_valid & (req_tag == line_tag);
  // Compared against the latched tag, so it also catches writes to a line still being filled.
  assign push_in_line = push & (req_tag == line_tag);
  assign push_ent     = '{addr: 32'(word_addr), data: wbs_dat_i, sel: wbs_sel_i};
  assign unused_bits  = ^{wbs_adr_i[31:ADDR_W+2], wbs_adr_i[1:0], head_ent.addr[31:ADDR_W]};

  sync_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(WFIFO_DEPTH)
  ) u_wfifo (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dat (head_ent)
  );

  always_ff @(posedge wb_clk_i) begin
    if (state == RD_WAIT && ctrl_out_valid_i) line_mem[idx] <= ctrl_data_i;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state           <= IDLE;
      line_tag        <= '0;
      line_valid      <= 1'b0;
      fill_dirty      <= 1'b0;
      idx             <= '0;
      req_off         <= '0;
      wbs_ack_o       <= 1'b0;
      wbs_dat_o       <= '0;
      ctrl_addr_o     <= '0;
      ctrl_rw_o       <= 1'b0;
      ctrl_data_o     <= '0;
      ctrl_mask_o     <= '0;
      ctrl_in_valid_o <= 1'b0;
    end else begin
      wbs_ack_o       <= push;
      ctrl_in_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state <= WR_ISSUE;
          end else if (hit) begin
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= 32'(line_mem[req_idx]);
          end else if (rd_req) begin
            state      <= RD_ISSUE;
            line_tag   <= req_tag;
            line_valid <= 1'b0;
            fill_dirty <= 1'b0;
            idx        <= '0;
            req_off    <= req_idx;
          end
        end
        WR_ISSUE: begin
          if (!ctrl_busy_i) begin
            ctrl_in_valid_o <= 1'b1;
            ctrl_rw_o       <= 1'b1;
            ctrl_addr_o     <= head_ent.addr[ADDR_W-1:0];
            ctrl_data_o     <= DATA_W'(head_ent.data);
            ctrl_mask_o     <= head_ent.sel;
            state           <= IDLE;
          end
        end
        RD_ISSUE: begin
          if (!ctrl_busy_i) begin
            ctrl_in_valid_o <= 1'b1;
            ctrl_rw_o       <= 1'b0;
            ctrl_addr_o     <= (line_tag << OFF_W) | ADDR_W'(idx);
            ctrl_data_o     <= '0;
            ctrl_mask_o     <= '0;
            state           <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (ctrl_out_valid_i) begin
            if (idx == LAST_IDX) begin
              // Ack is raised here so it is visible during RD_RESP, one cycle after the last word.
              line_valid <= ~fill_dirty;
              wbs_ack_o  <= 1'b1;
              wbs_dat_o  <= 32'((req_off == idx) ? ctrl_data_i : line_mem[req_off]);
              state      <= RD_RESP;
            end else begin
              idx   <= idx + 1'b1;
              state <= RD_ISSUE;
            end
          end
        end
        RD_RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (push_in_line) begin
        line_valid <= 1'b0;
        fill_dirty <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_sdram_bridge.sv
// Bench for wb_sdram_bridge: directed scenarios plus randomized traffic against a word-memory reference
// and a behavioural controller that records every command it accepts.
module tb_wb_sdram_bridge;

  typedef struct {
    logic [22:0] addr;
    logic        rw;
    logic [31:0] data;
    logic [3:0]  mask;
  } cmd_t;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = '0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [22:0] ctrl_addr_o;
  logic        ctrl_rw_o;
  logic [31:0] ctrl_data_o;
  logic [3:0]  ctrl_mask_o;
  logic        ctrl_in_valid_o;
  logic        ctrl_busy_i;
  logic [31:0] ctrl_data_i;
  logic        ctrl_out_valid_i;

  cmd_t        cmd_log[$];
  cmd_t        exp_wr[$];
  logic [31:0] sdram[int];
  logic [31:0] ref_mem[int];
  logic        force_busy = 1'b0;
  int          n_checks = 0, n_fail = 0, ack_cnt = 0;

  always #5 clk = ~clk;

  wb_sdram_bridge dut (
    .wb_clk_i         (clk),
    .wb_rst_i         (wb_rst_i),
    .wbs_stb_i        (wbs_stb_i),
    .wbs_cyc_i        (wbs_cyc_i),
    .wbs_we_i         (wbs_we_i),
    .wbs_sel_i        (wbs_sel_i),
    .wbs_adr_i        (wbs_adr_i),
    .wbs_dat_i        (wbs_dat_i),
    .wbs_ack_o        (wbs_ack_o),
    .wbs_dat_o        (wbs_dat_o),
    .ctrl_addr_o      (ctrl_addr_o),
    .ctrl_rw_o        (ctrl_rw_o),
    .ctrl_data_o      (ctrl_data_o),
    .ctrl_mask_o      (ctrl_mask_o),
    .ctrl_in_valid_o  (ctrl_in_valid_o),
    .ctrl_busy_i      (ctrl_busy_i),
    .ctrl_data_i      (ctrl_data_i),
    .ctrl_out_valid_i (ctrl_out_valid_i)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Unwritten SDRAM words read back as their word address + 0x100.
  function automatic logic [31:0] sd_get(input int a);
    return sdram.exists(a) ? sdram[a] : 32'(a) + 32'h100;
  endfunction

  function automatic logic [31:0] ref_get(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'(a) + 32'h100;
  endfunction

  always @(negedge clk) if (wbs_ack_o) ack_cnt++;

  initial begin : ctrl_model
    int          busy_cnt = 0;
    int          rd_delay = 0;
    logic        rd_pend = 1'b0;
    logic [22:0] rd_addr = '0;
    ctrl_busy_i = 1'b0; ctrl_out_valid_i = 1'b0; ctrl_data_i = '0;
    forever begin
      @(negedge clk);
      ctrl_out_valid_i = 1'b0;
      if (wb_rst_i) begin
        busy_cnt = 0;
        rd_pend  = 1'b0;
      end else begin
        if (busy_cnt > 0) busy_cnt--;
        if (rd_pend) begin
          if (rd_delay == 0) begin
            ctrl_out_valid_i = 1'b1;
            ctrl_data_i      = sd_get(int'(rd_addr));
            rd_pend          = 1'b0;
          end else rd_delay--;
        end
        if (ctrl_in_valid_o) begin
          cmd_log.push_back('{ctrl_addr_o, ctrl_rw_o, ctrl_data_o, ctrl_mask_o});
          busy_cnt = $urandom_range(1, 3);
          if (ctrl_rw_o) sdram[int'(ctrl_addr_o)] = merge(sd_get(int'(ctrl_addr_o)), ctrl_data_o, ctrl_mask_o);
          else begin
            rd_pend  = 1'b1;
            rd_addr  = ctrl_addr_o;
            rd_delay = $urandom_range(1, 4);
          end
        end
      end
      ctrl_busy_i = force_busy | (busy_cnt != 0);
    end
  end

  task automatic wb_xfer(input string tag, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdat, output int lat);
    @(posedge clk);
    @(negedge clk);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!wbs_ack_o && lat < 400);
    check({tag, "_ack"}, wbs_ack_o, 1'b1);
    rdat = wbs_dat_o;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    if (we && wbs_ack_o) ref_mem[int'(adr[24:2])] = merge(ref_get(int'(adr[24:2])), dat, sel);
  endtask

  task automatic wb_write(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output int lat);
    logic [31:0] unused_rd;
    wb_xfer(tag, 1'b1, adr, dat, sel, unused_rd, lat);
    exp_wr.push_back('{adr[24:2], 1'b1, dat, sel});
  endtask

  task automatic wb_read(input string tag, input logic [31:0] adr, input int exp_lat);
    logic [31:0] rd;
    int          lat;
    wb_xfer(tag, 1'b0, adr, '0, 4'h0, rd, lat);
    check({tag, "_data"}, rd, ref_get(int'(adr[24:2])));
    if (exp_lat > 0) check({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic wait_log(input string tag, input int n);
    int k = 0;
    while (cmd_log.size() < n && k < 300) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    check(tag, cmd_log.size(), n);
  endtask

  task automatic check_cmd(input string tag, input int i, input logic [22:0] a, input logic rw,
                           input logic [31:0] d, input logic [3:0] m);
    check({tag, "_addr"}, cmd_log[i].addr, a);
    check({tag, "_rw"}, cmd_log[i].rw, rw);
    check({tag, "_mask"}, cmd_log[i].mask, m);
    if (rw) check({tag, "_wdata"}, cmd_log[i].data, d);
  endtask

  task automatic check_quiet(input string p);
    check({p, "_ack"}, wbs_ack_o, 0);
    check({p, "_dat"}, wbs_dat_o, 0);
    check({p, "_caddr"}, ctrl_addr_o, 0);
    check({p, "_crw"}, ctrl_rw_o, 0);
    check({p, "_cdata"}, ctrl_data_o, 0);
    check({p, "_cmask"}, ctrl_mask_o, 0);
    check({p, "_cvalid"}, ctrl_in_valid_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, lat5, lat6, base, acks0, wbase;
    logic [31:0] wd[6];
    int          widx;

    repeat (3) @(posedge clk);
    #1 check_quiet("reset");
    @(negedge clk) wb_rst_i = 1'b0;

    // Single posted write.
    wb_write("w1", 32'h10, 32'hDEADBEEF, 4'hF, lat);
    check("w1_lat", lat, 1);
    wait_log("w1_cmds", 1);
    repeat (10) @(posedge clk);
    check("w1_single", cmd_log.size(), 1);
    check_cmd("w1_cmd", 0, 23'd4, 1'b1, 32'hDEADBEEF, 4'hF);

    // FIFO fill under a stuck controller.
    @(negedge clk) force_busy = 1'b1;
    base = cmd_log.size();
    for (int i = 0; i < 6; i++) wd[i] = $urandom;
    for (int i = 0; i < 4; i++) begin
      wb_write($sformatf("bb%0d", i), 32'h200 + 32'(4 * i), wd[i], 4'hF, lat);
      check($sformatf("bb%0d_lat", i), lat, 1);
    end
    fork
      begin
        wb_write("bb4", 32'h210, wd[4], 4'hF, lat5);
        wb_write("bb5", 32'h214, wd[5], 4'hF, lat6);
      end
      begin
        repeat (30) @(posedge clk);
        check("bb_busy_no_cmd", cmd_log.size(), base);
        @(negedge clk) force_busy = 1'b0;
      end
    join
    check("bb4_stalled", lat5 >= 30, 1'b1);
    wait_log("bb_cmds", base + 6);
    for (int i = 0; i < 6; i++)
      check_cmd($sformatf("bb_cmd%0d", i), base + i, 23'(128 + i), 1'b1, wd[i], 4'hF);

    // Line refill, then hits with no controller traffic.
    base = cmd_log.size();
    wb_read("r40", 32'h40, 0);
    check("r40_cmds", cmd_log.size(), base + 4);
    for (int i = 0; i < 4; i++)
      check_cmd($sformatf("r40_cmd%0d", i), base + i, 23'(16 + i), 1'b0, '0, 4'h0);
    wb_read("r44", 32'h44, 1);
    wb_read("r48", 32'h48, 1);
    wb_read("r4c", 32'h4C, 1);
    repeat (5) @(posedge clk);
    check("hit_no_cmds", cmd_log.size(), base + 4);

    // A write into the valid line forces the next read to refill after the drain.
    wb_write("w44", 32'h44, 32'hA5A5A5A5, 4'hF, lat);
    check("w44_lat", lat, 1);
    base = cmd_log.size();
    wb_read("r48b", 32'h48, 0);
    check("r48b_cmds", cmd_log.size(), base + 5);
    check_cmd("r48b_wr", base, 23'd17, 1'b1, 32'hA5A5A5A5, 4'hF);
    for (int i = 0; i < 4; i++)
      check_cmd($sformatf("r48b_rd%0d", i), base + 1 + i, 23'(16 + i), 1'b0, '0, 4'h0);
    wb_read("r44b", 32'h44, 1);

    // Reset while a refill waits for controller data.
    base = cmd_log.size();
    @(posedge clk);
    @(negedge clk);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h80; wbs_sel_i = 4'h0;
    for (int k = 0; k < 200 && cmd_log.size() == base; k++) begin
      @(posedge clk); #2;
    end
    check("rst_refill_started", cmd_log.size(), base + 1);
    acks0 = ack_cnt;
    wb_rst_i = 1'b1; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    @(posedge clk); #1;
    check_quiet("midrst");
    @(negedge clk) wb_rst_i = 1'b0;
    repeat (8) @(posedge clk);
    check("midrst_no_ack", ack_cnt, acks0);
    base = cmd_log.size();
    wb_read("r80", 32'h80, 0);
    check("r80_miss_cmds", cmd_log.size(), base + 4);

    // Randomized traffic over words 0..31.
    exp_wr.delete();
    wbase = cmd_log.size();
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 31)) << 2;
      if ($urandom_range(0, 1) == 1) wb_write("rnd_w", a, $urandom, 4'($urandom_range(1, 15)), lat);
      else                           wb_read($sformatf("rnd_r%0d", n), a, 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    repeat (40) @(posedge clk);
    widx = 0;
    for (int i = wbase; i < cmd_log.size(); i++) begin
      if (cmd_log[i].rw && widx < exp_wr.size()) begin
        check($sformatf("rnd_wcmd%0d_addr", widx), cmd_log[i].addr, exp_wr[widx].addr);
        check($sformatf("rnd_wcmd%0d_data", widx), cmd_log[i].data, exp_wr[widx].data);
        check($sformatf("rnd_wcmd%0d_mask", widx), cmd_log[i].mask, exp_wr[widx].mask);
        widx++;
      end else if (cmd_log[i].rw) widx++;
    end
    check("rnd_wcmd_count", widx, exp_wr.size());

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
